// File: rtl/usb_sie_pkg.sv
// Shared SIE definitions: PID codes and classifier, CRC5/CRC16 constants, FSM state encoding.
// Used by the RX packet checker, the TX stream mux and the CRC generators.
package usb_sie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHAKE,
    ST_DISCARD,
    ST_DONE
  } sie_state_e;

  typedef enum logic [1:0] {
    PID_CLASS_BAD,
    PID_CLASS_TOKEN,
    PID_CLASS_DATA,
    PID_CLASS_HSHAKE
  } pid_class_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  CRC5_INIT     = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam int TOKEN_FIELD_BITS   = 11;
  localparam int TOKEN_PAYLOAD_BITS = 16;
  localparam int DATA_MIN_BITS      = 16;
  localparam int PAY_CNT_W          = 14;

  // Check nibble must be the complement of the type nibble before the type is trusted.
  function automatic pid_class_e pid_class(input logic [7:0] pid_byte);
    pid_class_e cls;
    cls = PID_CLASS_BAD;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_byte[3:0])
        PID_OUT, PID_IN, PID_SOF, PID_SETUP: cls = PID_CLASS_TOKEN;
        PID_DATA0, PID_DATA1:                cls = PID_CLASS_DATA;
        PID_ACK, PID_NAK, PID_STALL:         cls = PID_CLASS_HSHAKE;
        default:                             cls = PID_CLASS_BAD;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/usb_rx_crc.sv
// Serial CRC residue checker, one bit per enabled cycle, register shifted MSB-out.
// residue_match is combinational from the register; no backpressure, caller gates with enable.
module usb_rx_crc #(
  parameter int                 WIDTH   = 5,
  parameter logic [WIDTH-1:0]   POLY    = '0,
  parameter logic [WIDTH-1:0]   INIT    = '1,
  parameter logic [WIDTH-1:0]   RESIDUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic data_bit,
  output logic residue_match
);

  logic [WIDTH-1:0] crc;
  logic             fb;

  assign fb = data_bit ^ crc[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= INIT;
    end else if (clear) begin
      crc <= INIT;
    end else if (enable) begin
      crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  assign residue_match = (crc == RESIDUE);

endmodule

// File: rtl/usb_rx_pkt_checker.sv
// RX packet checker: PID decode/check, token/data/handshake split, CRC5/CRC16 residue, CRC-stripped payload.
// pid_valid and byte strobes 1 cycle after the deciding bit, pkt_done 1 cycle after EOP; no backpressure.
module usb_rx_pkt_checker
  import usb_sie_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_bit,
  output logic [3:0]  pid,
  output logic        pid_valid,
  output logic        Token_pkt,
  output logic        Data_pkt,
  output logic [10:0] token_field,
  output logic [7:0]  data_byte,
  output logic        data_byte_valid,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        pid_err,
  output logic        len_err
);

  sie_state_e           state_q, state_d;
  pid_class_e           cls;
  logic                 armed;
  logic [7:0]           pid_sr;
  logic [2:0]           pid_cnt;
  logic [PAY_CNT_W-1:0] pay_cnt;
  logic [7:0]           byte_sr;
  logic [7:0]           hold0;
  logic [7:0]           hold1;
  logic [1:0]           hold_cnt;
  logic [7:0]           pid_next;
  logic [7:0]           byte_next;
  logic                 take;
  logic                 start;
  logic                 eop;
  logic                 pid_last;
  logic                 in_payload;
  logic                 len_bad;
  logic                 crc_good;
  logic                 crc5_match;
  logic                 crc16_match;

  // A packet may only begin once rx_active has been seen low, so a reset mid-packet skips the tail.
  assign take       = rx_active & rx_valid;
  assign start      = take & armed & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign eop        = ~rx_active & (state_q != ST_IDLE) & (state_q != ST_DONE);
  assign pid_last   = take & (state_q == ST_PID) & (pid_cnt == 3'd7);
  assign in_payload = (state_q == ST_TOKEN) | (state_q == ST_DATA) | (state_q == ST_HSHAKE);
  assign pid_next   = {rx_bit, pid_sr[7:1]};
  assign byte_next  = {rx_bit, byte_sr[7:1]};
  assign cls        = pid_class(pid_next);

  usb_rx_crc #(
    .WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT), .RESIDUE(CRC5_RESIDUE)
  ) u_crc5 (
    .clk(clk), .rst(rst), .clear(start), .enable(take & (state_q == ST_TOKEN)),
    .data_bit(rx_bit), .residue_match(crc5_match)
  );

  usb_rx_crc #(
    .WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .RESIDUE(CRC16_RESIDUE)
  ) u_crc16 (
    .clk(clk), .rst(rst), .clear(start), .enable(take & (state_q == ST_DATA)),
    .data_bit(rx_bit), .residue_match(crc16_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_PID : ST_IDLE;
      ST_PID: begin
        if (!rx_active) begin
          state_d = ST_DONE;
        end else if (pid_last) begin
          case (cls)
            PID_CLASS_TOKEN:  state_d = ST_TOKEN;
            PID_CLASS_DATA:   state_d = ST_DATA;
            PID_CLASS_HSHAKE: state_d = ST_HSHAKE;
            default:          state_d = ST_DISCARD;
          endcase
        end
      end
      default: if (!rx_active) state_d = ST_DONE;
    endcase
  end

  always_comb begin
    len_bad  = 1'b0;
    crc_good = 1'b0;
    case (state_q)
      ST_PID: len_bad = 1'b1;
      ST_TOKEN: begin
        len_bad  = (pay_cnt != PAY_CNT_W'(TOKEN_PAYLOAD_BITS));
        crc_good = crc5_match;
      end
      ST_DATA: begin
        len_bad  = (pay_cnt[2:0] != 3'd0) || (pay_cnt < PAY_CNT_W'(DATA_MIN_BITS));
        crc_good = crc16_match;
      end
      ST_HSHAKE: begin
        len_bad  = (pay_cnt != '0);
        crc_good = 1'b1;
      end
      default: begin
        len_bad  = 1'b0;
        crc_good = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed           <= 1'b0;
      pid_sr          <= '0;
      pid_cnt         <= '0;
      pay_cnt         <= '0;
      byte_sr         <= '0;
      hold0           <= '0;
      hold1           <= '0;
      hold_cnt        <= '0;
      pid             <= '0;
      pid_valid       <= 1'b0;
      Token_pkt       <= 1'b0;
      Data_pkt        <= 1'b0;
      token_field     <= '0;
      data_byte       <= '0;
      data_byte_valid <= 1'b0;
      pkt_done        <= 1'b0;
      crc_ok          <= 1'b0;
      pid_err         <= 1'b0;
      len_err         <= 1'b0;
    end else begin
      pid_valid       <= 1'b0;
      data_byte_valid <= 1'b0;
      pkt_done        <= 1'b0;
      if (!rx_active) armed <= 1'b1;

      if (start) begin
        pid_sr    <= pid_next;
        pid_cnt   <= 3'd1;
        pay_cnt   <= '0;
        hold_cnt  <= '0;
        Token_pkt <= 1'b0;
        Data_pkt  <= 1'b0;
        crc_ok    <= 1'b0;
        pid_err   <= 1'b0;
        len_err   <= 1'b0;
      end

      if (take && state_q == ST_PID) begin
        pid_sr  <= pid_next;
        pid_cnt <= pid_cnt + 3'd1;
        if (pid_last) begin
          pid       <= pid_next[3:0];
          pid_valid <= 1'b1;
          case (cls)
            PID_CLASS_TOKEN: Token_pkt <= 1'b1;
            PID_CLASS_DATA:  Data_pkt  <= 1'b1;
            PID_CLASS_BAD:   pid_err   <= 1'b1;
            default: ;
          endcase
        end
      end

      if (take && in_payload) begin
        if (pay_cnt != '1) pay_cnt <= pay_cnt + PAY_CNT_W'(1);
        if (state_q == ST_TOKEN && pay_cnt < PAY_CNT_W'(TOKEN_FIELD_BITS))
          token_field <= {rx_bit, token_field[10:1]};
        if (state_q == ST_DATA) begin
          byte_sr <= byte_next;
          // Two-deep hold: the last two bytes of any packet are the CRC and never leave.
          if (pay_cnt[2:0] == 3'd7) begin
            if (hold_cnt == 2'd2) begin
              data_byte       <= hold0;
              data_byte_valid <= 1'b1;
              hold0           <= hold1;
              hold1           <= byte_next;
            end else if (hold_cnt == 2'd1) begin
              hold1    <= byte_next;
              hold_cnt <= 2'd2;
            end else begin
              hold0    <= byte_next;
              hold_cnt <= 2'd1;
            end
          end
        end
      end

      if (eop) begin
        pkt_done <= 1'b1;
        len_err  <= len_bad;
        crc_ok   <= crc_good & ~len_bad;
        if (state_q == ST_PID) pid_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_checker.sv
// Directed bench for usb_rx_pkt_checker: hand-built packets, flags and payload checked at pkt_done.
// CRC bytes for non-trivial packets come from reflected (LSB-first) reference CRC functions.
module tb_usb_rx_pkt_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_bit;
  logic [3:0]  pid;
  logic        pid_valid;
  logic        Token_pkt;
  logic        Data_pkt;
  logic [10:0] token_field;
  logic [7:0]  data_byte;
  logic        data_byte_valid;
  logic        pkt_done;
  logic        crc_ok;
  logic        pid_err;
  logic        len_err;

  usb_rx_pkt_checker dut (
    .clk(clk), .rst(rst), .rx_active(rx_active), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .pid(pid), .pid_valid(pid_valid), .Token_pkt(Token_pkt), .Data_pkt(Data_pkt),
    .token_field(token_field), .data_byte(data_byte), .data_byte_valid(data_byte_valid),
    .pkt_done(pkt_done), .crc_ok(crc_ok), .pid_err(pid_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         n_strobes = 0;
  int         n_pidv    = 0;
  int         n_done    = 0;
  int         lat;
  logic       pre_done;
  logic [7:0] got_bytes [0:63];
  logic [7:0] pkt [0:7];

  always @(negedge clk) begin
    if (data_byte_valid) begin
      if (n_strobes < 64) got_bytes[n_strobes] = data_byte;
      n_strobes++;
    end
    if (pid_valid) n_pidv++;
    if (pkt_done) n_done++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, crc_ok, pid_err, len_err};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({pid, pid_valid, Token_pkt, Data_pkt, token_field, data_byte,
                data_byte_valid, pkt_done, crc_ok, pid_err, len_err});
  endfunction

  function automatic logic [15:0] crc16_usb(input int nbytes);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 1; i <= nbytes; i++)
      for (int j = 0; j < 8; j++)
        if (r[0] ^ pkt[i][j]) r = (r >> 1) ^ 16'hA001;
        else                  r = r >> 1;
    return ~r;
  endfunction

  function automatic logic [4:0] crc5_usb(input logic [10:0] f);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++)
      if (r[0] ^ f[i]) r = (r >> 1) ^ 5'h14;
      else             r = r >> 1;
    return ~r;
  endfunction

  task automatic set_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = b3;
    pkt[4] = 8'h00; pkt[5] = 8'h00; pkt[6] = 8'h00; pkt[7] = 8'h00;
  endtask

  task automatic drive(input logic a, input logic v, input logic b);
    rx_active = a; rx_valid = v; rx_bit = b;
    @(posedge clk); #1;
  endtask

  // Sends nbits LSB-first, drops rx_active, and measures cycles until pkt_done (lat = -1 on timeout).
  task automatic send_pkt(input int nbits, input int gap_max);
    for (int i = 0; i < nbits; i++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 1);
        for (int k = 0; k < g; k++) drive(1'b1, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b1, pkt[i / 8][i % 8]);
    end
    rx_active = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    pre_done = pkt_done;
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (pkt_done) lat = k;
    end
  endtask

  initial begin
    int s0, v0, d0;
    logic [10:0] fld;
    logic [4:0]  c5;
    logic [15:0] c16;

    rst = 1'b0; rx_active = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    #12;
    check_eq("reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // SETUP addr 0 endp 0
    set_pkt(8'h2D, 8'h00, 8'h10, 8'h00);
    v0 = n_pidv;
    send_pkt(24, 0);
    check_eq("setup_done_early", 32'(pre_done), 0);
    check_eq("setup_done_lat", 32'(lat), 1);
    check_eq("setup_pid", 32'(pid), 32'hD);
    check_eq("setup_kind", 32'({Token_pkt, Data_pkt}), 2);
    check_eq("setup_field", 32'(token_field), 0);
    check_eq("setup_flags", flags(), 4);
    check_eq("setup_pidv", 32'(n_pidv - v0), 1);

    // IN addr 0x15 endp 0xE
    fld = {4'hE, 7'h15};
    c5 = crc5_usb(fld);
    set_pkt(8'h69, fld[7:0], {c5, fld[10:8]}, 8'h00);
    send_pkt(24, 0);
    check_eq("in_field", 32'(token_field), 32'h715);
    check_eq("in_pid", 32'(pid), 32'h9);
    check_eq("in_flags", flags(), 4);

    // Zero-length DATA0
    set_pkt(8'hC3, 8'h00, 8'h00, 8'h00);
    s0 = n_strobes;
    send_pkt(24, 0);
    check_eq("zlp_kind", 32'({Token_pkt, Data_pkt}), 1);
    check_eq("zlp_strobes", 32'(n_strobes - s0), 0);
    check_eq("zlp_flags", flags(), 4);

    // DATA1 payload 01 02 03
    set_pkt(8'h4B, 8'h01, 8'h02, 8'h03);
    c16 = crc16_usb(3);
    pkt[4] = c16[7:0]; pkt[5] = c16[15:8];
    s0 = n_strobes;
    send_pkt(48, 0);
    check_eq("d1_strobes", 32'(n_strobes - s0), 3);
    check_eq("d1_byte0", 32'(got_bytes[s0]), 32'h01);
    check_eq("d1_byte1", 32'(got_bytes[s0 + 1]), 32'h02);
    check_eq("d1_byte2", 32'(got_bytes[s0 + 2]), 32'h03);
    check_eq("d1_flags", flags(), 4);
    check_eq("d1_pid", 32'(pid), 32'hB);

    // Same packet, one payload bit flipped
    pkt[2] = 8'h03;
    s0 = n_strobes;
    send_pkt(48, 0);
    check_eq("d1bad_strobes", 32'(n_strobes - s0), 3);
    check_eq("d1bad_flags", flags(), 0);

    // ACK
    set_pkt(8'hD2, 8'h00, 8'h00, 8'h00);
    send_pkt(8, 0);
    check_eq("ack_pid", 32'(pid), 32'h2);
    check_eq("ack_kind", 32'({Token_pkt, Data_pkt}), 0);
    check_eq("ack_flags", flags(), 4);

    // Bad PID check nibble
    set_pkt(8'hD3, 8'h00, 8'h00, 8'h00);
    v0 = n_pidv;
    send_pkt(8, 0);
    check_eq("badpid_flags", flags(), 2);
    check_eq("badpid_pidv", 32'(n_pidv - v0), 1);

    // Token truncated to 20 bits
    set_pkt(8'h2D, 8'h00, 8'h10, 8'h00);
    send_pkt(20, 0);
    check_eq("trunc_flags", flags(), 1);
    check_eq("trunc_token", 32'(Token_pkt), 1);

    // Token with rx_valid gaps
    send_pkt(24, 3);
    check_eq("gap_flags", flags(), 4);
    check_eq("gap_field", 32'(token_field), 0);
    check_eq("gap_pid", 32'(pid), 32'hD);
    check_eq("gap_lat", 32'(lat), 1);

    // Handshake followed by stray byte
    set_pkt(8'hD2, 8'hFF, 8'h00, 8'h00);
    send_pkt(16, 0);
    check_eq("hs_extra_flags", flags(), 1);

    // DATA0 with 19 payload bits
    set_pkt(8'hC3, 8'h00, 8'h00, 8'h00);
    s0 = n_strobes;
    send_pkt(27, 0);
    check_eq("d0_odd_flags", flags(), 1);
    check_eq("d0_odd_strobes", 32'(n_strobes - s0), 0);

    // rx_active drops after 5 PID bits
    set_pkt(8'hD2, 8'h00, 8'h00, 8'h00);
    v0 = n_pidv;
    send_pkt(5, 0);
    check_eq("midpid_flags", flags(), 3);
    check_eq("midpid_pidv", 32'(n_pidv - v0), 0);
    check_eq("midpid_lat", 32'(lat), 1);

    // Reset after 12 bits of a DATA1 packet; the tail must be ignored
    set_pkt(8'h4B, 8'h01, 8'h02, 8'h03);
    c16 = crc16_usb(3);
    pkt[4] = c16[7:0]; pkt[5] = c16[15:8];
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, pkt[i / 8][i % 8]);
    rst = 1'b0;
    #1;
    check_eq("midreset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = n_pidv;
    d0 = n_done;
    for (int i = 12; i < 48; i++) drive(1'b1, 1'b1, pkt[i / 8][i % 8]);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_eq("tail_pidv", 32'(n_pidv - v0), 0);
    check_eq("tail_done", 32'(n_done - d0), 0);

    set_pkt(8'hD2, 8'h00, 8'h00, 8'h00);
    send_pkt(8, 0);
    check_eq("post_reset_ack_lat", 32'(lat), 1);
    check_eq("post_reset_ack_pid", 32'(pid), 32'h2);
    check_eq("post_reset_ack_flags", flags(), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
